// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: three execution-unit result channels in, one registered
// common-data-bus broadcast out.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH_BIT = 5
);
    logic                     alu_valid;
    logic [ROB_WIDTH_BIT-1:0] alu_rob_id;
    logic [31:0]              alu_val;
    logic                     alu_ready;

    logic                     lsb_valid;
    logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
    logic [31:0]              lsb_val;
    logic                     lsb_ready;

    logic                     br_valid;
    logic [ROB_WIDTH_BIT-1:0] br_rob_id;
    logic [31:0]              br_val;
    logic                     br_ready;

    logic                     cdb_valid;
    logic [ROB_WIDTH_BIT-1:0] cdb_rob_id;
    logic [31:0]              cdb_val;
    logic [1:0]               cdb_src;

    // Execution units and ROB side
    modport master (
        output alu_valid, alu_rob_id, alu_val,
        output lsb_valid, lsb_rob_id, lsb_val,
        output br_valid, br_rob_id, br_val,
        input  alu_ready, lsb_ready, br_ready,
        input  cdb_valid, cdb_rob_id, cdb_val, cdb_src
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rob_id, alu_val,
        input  lsb_valid, lsb_rob_id, lsb_val,
        input  br_valid, br_rob_id, br_val,
        output alu_ready, lsb_ready, br_ready,
        output cdb_valid, cdb_rob_id, cdb_val, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus writeback arbiter. Each source (0 ALU, 1 LSB, 2 BR) owns a
// small FIFO; a round-robin scheduler drains at most one result per cycle onto
// a registered broadcast. A ROB clear flushes every buffered result.
module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT  = 5,
    parameter int FIFO_DEPTH_BIT = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_in,
    cdb_arbiter_if.slave  bus
);
    localparam int NSRC  = 3;
    localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
    localparam logic [FIFO_DEPTH_BIT:0] FULL_CNT = {1'b1, {FIFO_DEPTH_BIT{1'b0}}};

    typedef logic [ROB_WIDTH_BIT-1:0]  id_t;
    typedef logic [FIFO_DEPTH_BIT-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_BIT:0]   cnt_t;

    logic        in_valid [NSRC];
    id_t         in_id    [NSRC];
    logic [31:0] in_val   [NSRC];
    logic        src_ready[NSRC];
    logic        push     [NSRC];
    logic        pop      [NSRC];

    id_t         mem_id   [NSRC][DEPTH];
    logic [31:0] mem_val  [NSRC][DEPTH];
    ptr_t        head     [NSRC];
    ptr_t        tail     [NSRC];
    cnt_t        count    [NSRC];
    id_t         head_id  [NSRC];
    logic [31:0] head_val [NSRC];
    logic [2:0]  not_empty;

    logic [1:0]  rr_last;
    logic [1:0]  cand0, cand1, cand2;
    logic        gnt_vld;
    logic [1:0]  gnt_idx;
    id_t         gnt_id;
    logic [31:0] gnt_val;
    logic        advance;

    logic        cdb_valid_q;
    id_t         cdb_rob_id_q;
    logic [31:0] cdb_val_q;
    logic [1:0]  cdb_src_q;

    // Next index in the three-way rotation 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_succ(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Normal operation: clock enabled and no flush pending this edge.
    assign advance = rdy_in && !clear_in;

    // Gather the three source channels into indexable arrays.
    always_comb begin
        in_valid[0] = bus.alu_valid;
        in_id[0]    = bus.alu_rob_id;
        in_val[0]   = bus.alu_val;
        in_valid[1] = bus.lsb_valid;
        in_id[1]    = bus.lsb_rob_id;
        in_val[1]   = bus.lsb_val;
        in_valid[2] = bus.br_valid;
        in_id[2]    = bus.br_rob_id;
        in_val[2]   = bus.br_val;
    end

    // Ready looks only at occupancy, never at a same-cycle pop or at x_valid;
    // it is held low while reset is asserted.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            src_ready[s] = !rst_in && advance && (count[s] != FULL_CNT);
            push[s]      = in_valid[s] && src_ready[s];
            not_empty[s] = (count[s] != '0);
            head_id[s]   = mem_id[s][head[s]];
            head_val[s]  = mem_val[s][head[s]];
        end
    end

    assign bus.alu_ready = src_ready[0];
    assign bus.lsb_ready = src_ready[1];
    assign bus.br_ready  = src_ready[2];

    // Round-robin pick: start after the last winner, the last winner goes last.
    always_comb begin
        cand0   = rr_succ(rr_last);
        cand1   = rr_succ(cand0);
        cand2   = rr_last;
        gnt_vld = 1'b1;
        gnt_idx = cand0;
        if (not_empty[cand0]) begin
            gnt_idx = cand0;
        end else if (not_empty[cand1]) begin
            gnt_idx = cand1;
        end else if (not_empty[cand2]) begin
            gnt_idx = cand2;
        end else begin
            gnt_vld = 1'b0;
        end
        case (gnt_idx)
            2'd1:    begin gnt_id = head_id[1]; gnt_val = head_val[1]; end
            2'd2:    begin gnt_id = head_id[2]; gnt_val = head_val[2]; end
            default: begin gnt_id = head_id[0]; gnt_val = head_val[0]; end
        endcase
        pop[0] = advance && gnt_vld && (gnt_idx == 2'd0);
        pop[1] = advance && gnt_vld && (gnt_idx == 2'd1);
        pop[2] = advance && gnt_vld && (gnt_idx == 2'd2);
    end

    // FIFO storage: payload only, written at the tail on an accepted push.
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                mem_id[s][tail[s]]  <= in_id[s];
                mem_val[s][tail[s]] <= in_val[s];
            end
        end
    end

    // FIFO pointers, scheduler state and the registered CDB broadcast.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < NSRC; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            rr_last      <= 2'd2;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_val_q    <= '0;
            cdb_src_q    <= 2'd0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int s = 0; s < NSRC; s++) begin
                    head[s]  <= '0;
                    tail[s]  <= '0;
                    count[s] <= '0;
                end
                rr_last     <= 2'd2;
                cdb_valid_q <= 1'b0;
            end else begin
                for (int s = 0; s < NSRC; s++) begin
                    if (push[s]) tail[s] <= tail[s] + 1'b1;
                    if (pop[s])  head[s] <= head[s] + 1'b1;
                    if (push[s] && !pop[s]) begin
                        count[s] <= count[s] + 1'b1;
                    end else if (!push[s] && pop[s]) begin
                        count[s] <= count[s] - 1'b1;
                    end
                end
                cdb_valid_q <= gnt_vld;
                if (gnt_vld) begin
                    cdb_rob_id_q <= gnt_id;
                    cdb_val_q    <= gnt_val;
                    cdb_src_q    <= gnt_idx;
                    rr_last      <= gnt_idx;
                end
            end
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_val    = cdb_val_q;
    assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-written sequences for reset, latency
// and async reset, then a vector table for round-robin, backpressure, flush
// and freeze behaviour.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.ROB_WIDTH_BIT(5)) bus ();

    cdb_arbiter #(
        .ROB_WIDTH_BIT (5),
        .FIFO_DEPTH_BIT(1)
    ) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .rdy_in  (rdy),
        .clear_in(clr),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0] aid;   // 0 = no push from that source
        logic [4:0] lid;
        logic [4:0] bid;
        logic       clr;
        logic       rdy;
        logic [2:0] er;    // expected {alu_ready, lsb_ready, br_ready} before the edge
        logic       ev;    // expected cdb_valid after the edge
        logic [4:0] eid;   // expected (or held) cdb_rob_id after the edge
        logic [1:0] esrc;  // expected (or held) cdb_src after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int a, input int l, input int b, input int c, input int r,
                       input int er, input int ev, input int eid, input int esrc);
        vec_t v;
        v.aid  = a[4:0];
        v.lid  = l[4:0];
        v.bid  = b[4:0];
        v.clr  = c[0];
        v.rdy  = r[0];
        v.er   = er[2:0];
        v.ev   = ev[0];
        v.eid  = eid[4:0];
        v.esrc = esrc[1:0];
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] val_of(input logic [1:0] src, input logic [4:0] id);
        case (src)
            2'd0:    return 32'hA0A0_0000 | {27'd0, id};
            2'd1:    return 32'hB1B1_0000 | {27'd0, id};
            default: return 32'hC2C2_0000 | {27'd0, id};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] l, input logic [4:0] b);
        bus.alu_valid  = (a != 5'd0);
        bus.alu_rob_id = a;
        bus.alu_val    = val_of(2'd0, a);
        bus.lsb_valid  = (l != 5'd0);
        bus.lsb_rob_id = l;
        bus.lsb_val    = val_of(2'd1, l);
        bus.br_valid   = (b != 5'd0);
        bus.br_rob_id  = b;
        bus.br_val     = val_of(2'd2, b);
    endtask

    function automatic logic [31:0] readies();
        return {29'd0, bus.alu_ready, bus.lsb_ready, bus.br_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_val;

        // aid lid bid clr rdy ready  v  id src
        // Round robin with all sources pushing, FIFOs filling, then draining
        add( 1,  2,  3, 0, 1, 'b111, 0,  0, 0);
        add( 4,  5,  6, 0, 1, 'b111, 1,  1, 0);
        add( 7,  8,  9, 0, 1, 'b100, 1,  2, 1);
        add(10, 11, 12, 0, 1, 'b010, 1,  3, 2);
        add(13, 14, 15, 0, 1, 'b001, 1,  4, 0);
        add(16, 17, 18, 0, 1, 'b100, 1,  5, 1);
        add(19, 20, 21, 0, 1, 'b010, 1,  6, 2);
        add( 0,  0,  0, 0, 1, 'b001, 1,  7, 0);
        add( 0,  0,  0, 0, 1, 'b101, 1, 11, 1);
        add( 0,  0,  0, 0, 1, 'b111, 1, 15, 2);
        add( 0,  0,  0, 0, 1, 'b111, 1, 16, 0);
        add( 0,  0,  0, 0, 1, 'b111, 1, 20, 1);
        add( 0,  0,  0, 0, 1, 'b111, 0, 20, 1);
        // Rotation skips empty sources
        add( 0,  0, 30, 0, 1, 'b111, 0, 20, 1);
        add(31,  0,  0, 0, 1, 'b111, 1, 30, 2);
        add( 0,  0,  0, 0, 1, 'b111, 1, 31, 0);
        add( 0,  0,  0, 0, 1, 'b111, 0, 31, 0);
        // Flush with ALU holding 2, BR holding 1, same-cycle ALU push
        add(22, 23,  0, 0, 1, 'b111, 0, 31, 0);
        add(24,  0, 25, 0, 1, 'b111, 1, 23, 1);
        add(26,  0,  0, 1, 1, 'b000, 0, 23, 1);
        add( 0,  0,  0, 0, 1, 'b111, 0, 23, 1);
        add( 0,  0,  0, 0, 1, 'b111, 0, 23, 1);
        add(27, 28, 29, 0, 1, 'b111, 0, 23, 1);
        add( 0,  0,  0, 0, 1, 'b111, 1, 27, 0);
        add( 0,  0,  0, 0, 1, 'b111, 1, 28, 1);
        add( 0,  0,  0, 0, 1, 'b111, 1, 29, 2);
        add( 0,  0,  0, 0, 1, 'b111, 0, 29, 2);
        // Freeze for four cycles with cdb_valid high and entries queued
        add( 3,  4,  5, 0, 1, 'b111, 0, 29, 2);
        add( 0,  0,  0, 0, 1, 'b111, 1,  3, 0);
        add( 6,  0,  0, 0, 0, 'b000, 1,  3, 0);
        add( 0,  0,  0, 0, 0, 'b000, 1,  3, 0);
        add( 0,  0,  0, 1, 0, 'b000, 1,  3, 0);
        add( 0,  0,  0, 0, 0, 'b000, 1,  3, 0);
        add( 0,  0,  0, 0, 1, 'b111, 1,  4, 1);
        add( 0,  0,  0, 0, 1, 'b111, 1,  5, 2);
        add( 0,  0,  0, 0, 1, 'b111, 0,  5, 2);
        // Backpressure on LSB: 7, 8 fill it, third push refused until first grant
        add(12,  7, 10, 0, 1, 'b111, 0,  5, 2);
        add( 0,  8, 11, 0, 1, 'b111, 1, 12, 0);
        add( 0,  9, 13, 0, 1, 'b100, 1,  7, 1);
        add( 0,  9, 13, 0, 1, 'b110, 1, 10, 2);
        add( 0,  0, 13, 0, 1, 'b101, 1,  8, 1);
        add( 0,  0,  0, 0, 1, 'b110, 1, 11, 2);
        add( 0,  0,  0, 0, 1, 'b111, 1,  9, 1);
        add( 0,  0,  0, 0, 1, 'b111, 1, 13, 2);
        add( 0,  0,  0, 0, 1, 'b111, 0, 13, 2);

        // Reset state
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        drive(5'd0, 5'd0, 5'd0);
        #12;
        check("reset cdb_valid", {31'd0, bus.cdb_valid}, 32'd0);
        check("reset cdb_rob_id", {27'd0, bus.cdb_rob_id}, 32'd0);
        check("reset cdb_val", bus.cdb_val, 32'd0);
        check("reset cdb_src", {30'd0, bus.cdb_src}, 32'd0);
        check("reset readies", readies(), 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset readies", readies(), 32'd7);

        // Single ALU push: id 5, value 0x1234
        bus.alu_valid  = 1'b1;
        bus.alu_rob_id = 5'd5;
        bus.alu_val    = 32'h1234;
        tick();
        drive(5'd0, 5'd0, 5'd0);
        check("single edge1 valid", {31'd0, bus.cdb_valid}, 32'd0);
        tick();
        check("single edge2 valid", {31'd0, bus.cdb_valid}, 32'd1);
        check("single edge2 id", {27'd0, bus.cdb_rob_id}, 32'd5);
        check("single edge2 val", bus.cdb_val, 32'h1234);
        check("single edge2 src", {30'd0, bus.cdb_src}, 32'd0);
        tick();
        check("single edge3 valid", {31'd0, bus.cdb_valid}, 32'd0);

        // Async reset mid-stream (ALU granted last, so LSB would be next)
        drive(5'd1, 5'd2, 5'd3);
        tick();
        drive(5'd0, 5'd0, 5'd0);
        tick();
        check("pre-reset valid", {31'd0, bus.cdb_valid}, 32'd1);
        check("pre-reset src", {30'd0, bus.cdb_src}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async reset valid", {31'd0, bus.cdb_valid}, 32'd0);
        check("async reset id", {27'd0, bus.cdb_rob_id}, 32'd0);
        check("async reset val", bus.cdb_val, 32'd0);
        check("async reset readies", readies(), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("after async reset readies", readies(), 32'd7);
        drive(5'd11, 5'd12, 5'd13);
        tick();
        drive(5'd0, 5'd0, 5'd0);
        check("after reset push valid", {31'd0, bus.cdb_valid}, 32'd0);
        tick();
        check("after reset 1st src", {30'd0, bus.cdb_src}, 32'd0);
        check("after reset 1st id", {27'd0, bus.cdb_rob_id}, 32'd11);
        tick();
        check("after reset 2nd src", {30'd0, bus.cdb_src}, 32'd1);
        check("after reset 2nd id", {27'd0, bus.cdb_rob_id}, 32'd12);
        tick();
        check("after reset 3rd src", {30'd0, bus.cdb_src}, 32'd2);
        check("after reset 3rd id", {27'd0, bus.cdb_rob_id}, 32'd13);
        tick();
        check("after reset drained", {31'd0, bus.cdb_valid}, 32'd0);

        // Fresh reset, then the vector table
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].aid, vecs[i].lid, vecs[i].bid);
            clr = vecs[i].clr;
            rdy = vecs[i].rdy;
            #1;
            check($sformatf("row%0d readies", i + 1), readies(), {29'd0, vecs[i].er});
            tick();
            exp_val = (vecs[i].ev || vecs[i].eid != 5'd0) ? val_of(vecs[i].esrc, vecs[i].eid) : 32'd0;
            check($sformatf("row%0d cdb_valid", i + 1), {31'd0, bus.cdb_valid}, {31'd0, vecs[i].ev});
            check($sformatf("row%0d cdb_rob_id", i + 1), {27'd0, bus.cdb_rob_id}, {27'd0, vecs[i].eid});
            check($sformatf("row%0d cdb_src", i + 1), {30'd0, bus.cdb_src}, {30'd0, vecs[i].esrc});
            check($sformatf("row%0d cdb_val", i + 1), bus.cdb_val, exp_val);
        end
        drive(5'd0, 5'd0, 5'd0);
        clr = 1'b0;
        rdy = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter for the common data bus (CDB) that feeds the reorder buffer's result-set port. Three execution sources (ALU reservation station, load/store buffer, branch unit) each push results into a private small FIFO. A round-robin scheduler drains at most one result per cycle onto a registered CDB broadcast carrying ROB id and value. The block also flushes all buffered results when the ROB signals a misprediction clear.

## Interface
- ROB_WIDTH_BIT, default 5: width of ROB entry ids.
- FIFO_DEPTH_BIT, default 1: log2 of per-source FIFO depth (default depth 2).

- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; when low the block freezes.
- clear_in  input  1  ROB clear_flag; flush request.
- alu_valid / lsb_valid / br_valid  input  1 each  source has a result.
- alu_rob_id / lsb_rob_id / br_rob_id  input  ROB_WIDTH_BIT each  destination ROB entry.
- alu_val / lsb_val / br_val  input  32 each  result value.
- alu_ready / lsb_ready / br_ready  output  1 each  source FIFO can accept this cycle.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_rob_id  output  ROB_WIDTH_BIT  broadcast ROB id (registered).
- cdb_val  output  32  broadcast value (registered).
- cdb_src  output  2  granted source: 0 ALU, 1 LSB, 2 BR (registered).

## Operation
- Source index: 0 ALU, 1 LSB, 2 BR. Each source owns a FIFO of 2^FIFO_DEPTH_BIT entries. Each FIFO has head/tail pointers and a count of width FIFO_DEPTH_BIT+1. Pointers wrap modulo depth.
- Push: a push occurs when x_valid && x_ready at the edge. x_ready = rdy_in && !clear_in && (count != depth). x_ready does not credit a same-cycle pop. A full FIFO therefore refuses input even while being drained. x_valid while !x_ready is ignored; holding the result is the source's responsibility.
- Scheduler: 2-bit rr_last holds the last granted index. Candidate order is (rr_last+1)%3, (rr_last+2)%3, rr_last. The first candidate whose FIFO is non-empty is granted.
- On a grant, the head of that FIFO is popped and its id/value/src are registered onto the CDB, cdb_valid <= 1, and rr_last <= granted index.
- With no candidate non-empty: cdb_valid <= 0, and rr_last and the other CDB registers hold.
- The same FIFO may push and pop in one edge. Count is unchanged; head and tail both advance.
- Flush (clear_in && rdy_in at an edge):
  - all counts, heads and tails go to 0;
  - cdb_valid <= 0;
  - rr_last <= 2;
  - pushes and the grant for that cycle are discarded.
- Freeze (!rdy_in): no push, no pop, no flush, every register holds, all x_ready low. A held cdb_valid=1 is ignored by the ROB while rdy_in is low.
- Reset (asynchronous, any time, including mid-transfer): FIFOs empty; rr_last = 2; cdb_valid = 0, cdb_rob_id = 0, cdb_val = 0, cdb_src = 0. x_ready reads 0 during reset and 1 after reset deasserts if rdy_in is high.
- Fairness: a continuously non-empty source is granted at least once every 3 cycles.

## Timing
- Latency: result pushed at edge k -> earliest grant at edge k+1 -> cdb_valid high during cycle k+1..k+2. There is no same-cycle bypass.
- Throughput: one CDB broadcast per cycle sustained, while any FIFO is non-empty.
- x_ready is combinational from count, rdy_in and clear_in only. There is no path from x_valid to x_ready.
- CDB outputs are driven directly from registers.
- Reset is asynchronous: outputs reach reset values without a clock edge.

## Test plan
- Single ALU push: alu_rob_id=5, alu_val=0x1234 at edge 1 -> cdb_valid=1, cdb_rob_id=5, cdb_val=0x1234, cdb_src=0 after edge 2; cdb_valid=0 after edge 3.
- All three push at edge 1, with ids ALU=1, LSB=2, BR=3, and keep pushing new ids each cycle -> grant order ALU, LSB, BR, ALU, ...; each source is granted exactly once per 3 cycles.
- Backpressure: LSB pushes ids 7, 8 while a BR FIFO is continuously busy and LSB is not granted -> lsb_ready=0 once count=2, a third push is ignored, and lsb_ready returns to 1 the cycle after the first LSB grant.
- Flush: ALU FIFO holds 2 entries and BR holds 1; assert clear_in for one cycle with alu_valid=1 -> all FIFOs empty, cdb_valid=0, and no broadcast of any pre-flush or same-cycle id follows.
- Freeze: drop rdy_in for 4 cycles with entries queued and cdb_valid=1 -> outputs and pointers unchanged, all x_ready=0; broadcasts resume in the original round-robin order after rdy_in rises.
- Async reset mid-stream: pulse rst_in between clock edges while cdb_valid=1 -> cdb_valid=0 immediately; after release, the first grant goes to ALU when all three sources are queued.
